// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage data access path.
// Op codes, access-engine states, alignment exception codes and op-class helpers.
// Used by mem_access_unit and mem_lane_fmt (and the IF-side fetch unit).
package mem_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LBU = 3'd1,
    OP_LH  = 3'd2,
    OP_LHU = 3'd3,
    OP_LW  = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  function automatic logic op_is_load(input logic [2:0] op);
    return (op <= 3'd4);
  endfunction

  function automatic logic op_is_store(input logic [2:0] op);
    return (op >= 3'd5);
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatter: load extract/extend, store byte-enables/replication, alignment check.
// Latency: purely combinational. Backpressure: none (no state).
// Ports: op_i/addr_lo_i select the access; raw_i is the bus read word, wdata_i the store
// source; load_o, wdata_o, be_o, misaligned_o are the formatted results.
module mem_lane_fmt
  import mem_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] raw_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  be_o,
  output logic        misaligned_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel     = raw_i[{addr_lo_i, 3'b000} +: 8];
    half_sel     = addr_lo_i[1] ? raw_i[31:16] : raw_i[15:0];
    load_o       = raw_i;
    wdata_o      = wdata_i;
    be_o         = 4'b0000;
    misaligned_o = 1'b0;
    case (op_i)
      OP_LB:  load_o = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU: load_o = {24'h000000, byte_sel};
      OP_LH: begin
        load_o       = {{16{half_sel[15]}}, half_sel};
        misaligned_o = addr_lo_i[0];
      end
      OP_LHU: begin
        load_o       = {16'h0000, half_sel};
        misaligned_o = addr_lo_i[0];
      end
      OP_LW:  misaligned_o = |addr_lo_i;
      OP_SB: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      OP_SH: begin
        be_o         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o      = {2{wdata_i[15:0]}};
        misaligned_o = addr_lo_i[0];
      end
      OP_SW: begin
        be_o         = 4'b1111;
        misaligned_o = |addr_lo_i;
      end
      default: load_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data access engine: issues the EX/MEM load/store on a valid/ready bus, waits for the response.
// Latency: 3 cycles minimum (IDLE->REQ->WAIT->DONE); stall requested from issue until DONE.
// Backpressure: request fields held stable while req_ready_i is low; DONE holds while pipe_stall_i.
// Ports: pipeline side (op_valid_i/op_i/addr_i/wdata_i/except_pending_i/pipe_stall_i/pipe_flush_i in;
// mem_stall_o/mem_is_*_o/rdata_o/adel_o/ades_o/badvaddr_o/bus_err_o out); bus side req_* / rsp_*.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        except_pending_i,
  input  logic        pipe_stall_i,
  input  logic        pipe_flush_i,
  output logic        mem_stall_o,
  output logic        mem_is_load_o,
  output logic        mem_is_store_o,
  output logic [31:0] rdata_o,
  output logic        adel_o,
  output logic        ades_o,
  output logic [31:0] badvaddr_o,
  output logic        bus_err_o,
  output logic        req_o,
  output logic        req_we_o,
  output logic [31:0] req_addr_o,
  output logic [31:0] req_wdata_o,
  output logic [3:0]  req_be_o,
  input  logic        req_ready_i,
  input  logic        rsp_valid_i,
  input  logic [31:0] rsp_rdata_i
);

  // Expiry is detected on the last WAIT cycle, so the counter would read TIMEOUT_CYCLES
  // on the same edge that enters DONE with the error pulse.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);

  mem_state_e  state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  lane_q, lane_d;
  logic        req_we_q, req_we_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic [3:0]  req_be_q, req_be_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        bus_err_q, bus_err_d;

  logic        in_idle, go;
  logic [2:0]  fmt_op;
  logic [1:0]  fmt_lane;
  logic [31:0] fmt_load, fmt_wdata;
  logic [3:0]  fmt_be;
  logic        fmt_misaligned;

  // One formatter serves both phases: in IDLE it looks at the incoming op (store lanes,
  // alignment); afterwards it looks at the captured op to shape the returning load word.
  assign in_idle  = (state_q == ST_IDLE);
  assign fmt_op   = in_idle ? op_i : op_q;
  assign fmt_lane = in_idle ? addr_i[1:0] : lane_q;

  mem_lane_fmt u_fmt (
    .op_i         (fmt_op),
    .addr_lo_i    (fmt_lane),
    .raw_i        (rsp_rdata_i),
    .wdata_i      (wdata_i),
    .load_o       (fmt_load),
    .wdata_o      (fmt_wdata),
    .be_o         (fmt_be),
    .misaligned_o (fmt_misaligned)
  );

  assign go = op_valid_i & ~except_pending_i & ~fmt_misaligned & ~pipe_flush_i;

  assign mem_is_load_o  = op_valid_i & op_is_load(op_i);
  assign mem_is_store_o = op_valid_i & op_is_store(op_i);
  assign adel_o = in_idle & op_valid_i & ~except_pending_i & fmt_misaligned & op_is_load(op_i);
  assign ades_o = in_idle & op_valid_i & ~except_pending_i & fmt_misaligned & op_is_store(op_i);
  assign badvaddr_o = (adel_o | ades_o) ? addr_i : 32'h0;

  assign req_o       = (state_q == ST_REQ);
  assign req_we_o    = req_we_q;
  assign req_addr_o  = req_addr_q;
  assign req_wdata_o = req_wdata_q;
  assign req_be_o    = req_be_q;
  assign rdata_o     = rdata_q;
  assign bus_err_o   = bus_err_q;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    lane_d      = lane_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_be_d    = req_be_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    bus_err_d   = 1'b0;
    mem_stall_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          mem_stall_o = 1'b1;
          state_d     = ST_REQ;
          op_d        = op_i;
          lane_d      = addr_i[1:0];
          req_we_d    = op_is_store(op_i);
          req_addr_d  = {addr_i[31:2], 2'b00};
          req_wdata_d = fmt_wdata;
          req_be_d    = fmt_be;
        end
      end
      ST_REQ: begin
        mem_stall_o = 1'b1;
        if (req_ready_i) begin
          state_d = ST_WAIT;
          cnt_d   = 16'h0000;
        end
      end
      ST_WAIT: begin
        mem_stall_o = 1'b1;
        cnt_d       = cnt_q + 16'h0001;
        // A response on the expiry cycle still wins over the watchdog.
        if (rsp_valid_i) begin
          rdata_d = fmt_load;
          state_d = ST_DONE;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          bus_err_d = 1'b1;
          rdata_d   = 32'h0;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (~pipe_stall_i | pipe_flush_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= 3'd0;
      lane_q      <= 2'd0;
      req_we_q    <= 1'b0;
      req_addr_q  <= 32'h0;
      req_wdata_q <= 32'h0;
      req_be_q    <= 4'h0;
      cnt_q       <= 16'h0;
      rdata_q     <= 32'h0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      lane_q      <= lane_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_be_q    <= req_be_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      bus_err_q   <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit (watchdog set to 4 cycles).
// Directed scenarios plus randomized ops against an arithmetic reference model.
module tb_mem_access_unit;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid_i;
  logic [2:0]  op_i;
  logic [31:0] addr_i, wdata_i;
  logic        except_pending_i, pipe_stall_i, pipe_flush_i;
  logic        mem_stall_o, mem_is_load_o, mem_is_store_o;
  logic [31:0] rdata_o;
  logic        adel_o, ades_o;
  logic [31:0] badvaddr_o;
  logic        bus_err_o, req_o, req_we_o;
  logic [31:0] req_addr_o, req_wdata_o;
  logic [3:0]  req_be_o;
  logic        req_ready_i, rsp_valid_i;
  logic [31:0] rsp_rdata_i;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .op_valid_i(op_valid_i), .op_i(op_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .except_pending_i(except_pending_i), .pipe_stall_i(pipe_stall_i), .pipe_flush_i(pipe_flush_i),
    .mem_stall_o(mem_stall_o), .mem_is_load_o(mem_is_load_o), .mem_is_store_o(mem_is_store_o),
    .rdata_o(rdata_o), .adel_o(adel_o), .ades_o(ades_o), .badvaddr_o(badvaddr_o),
    .bus_err_o(bus_err_o), .req_o(req_o), .req_we_o(req_we_o), .req_addr_o(req_addr_o),
    .req_wdata_o(req_wdata_o), .req_be_o(req_be_o), .req_ready_i(req_ready_i),
    .rsp_valid_i(rsp_valid_i), .rsp_rdata_i(rsp_rdata_i)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (little-endian byte arithmetic) ----------------
  function automatic logic is_ld(input logic [2:0] op);
    return op <= 3'd4;
  endfunction

  function automatic logic model_misaligned(input logic [2:0] op, input logic [31:0] addr);
    if (op == 3'd2 || op == 3'd3 || op == 3'd6) return (addr % 2) != 0;
    if (op == 3'd4 || op == 3'd7) return (addr % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] raw);
    longint b, h, v;
    b = (raw >> (8 * (addr % 4))) & 32'hFF;
    h = (raw >> (16 * ((addr % 4) / 2))) & 32'hFFFF;
    case (op)
      3'd0:    v = (b >= 128) ? b - 256 : b;
      3'd1:    v = b;
      3'd2:    v = (h >= 32768) ? h - 65536 : h;
      3'd3:    v = h;
      default: v = raw;
    endcase
    return 32'(v);
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] op, input logic [31:0] addr);
    if (op == 3'd5) return 4'(1 << (addr % 4));
    if (op == 3'd6) return ((addr % 4) >= 2) ? 4'd12 : 4'd3;
    if (op == 3'd7) return 4'd15;
    return 4'd0;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] op, input logic [31:0] wd);
    if (op == 3'd5) return (wd & 32'hFF) * 32'h01010101;
    if (op == 3'd6) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    op_valid_i = 0; op_i = 0; addr_i = 0; wdata_i = 0;
    except_pending_i = 0; pipe_stall_i = 0; pipe_flush_i = 0;
    req_ready_i = 0; rsp_valid_i = 0; rsp_rdata_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 0;
    @(posedge clk); #1;
  endtask

  // Drives one op from IDLE through DONE acting as the bus; reports what it observed.
  // Cycle 0 is the IDLE cycle in which the op is presented.
  task automatic run_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] raw, input int rdly, input int rspd, input int hold,
                        input bit junk,
                        output int acc_cyc, output int done_cyc, output int berr_cyc,
                        output int berr_cnt, output int n_acc,
                        output bit stall_ok, output bit fields_ok, output bit hold_ok,
                        output logic r_we, output logic [31:0] r_addr, output logic [31:0] r_wdata,
                        output logic [3:0] r_be, output logic [31:0] r_rdata);
    int req_seen;
    bit have_req;
    acc_cyc = -1; done_cyc = -1; berr_cyc = -1; berr_cnt = 0; n_acc = 0;
    stall_ok = 1; fields_ok = 1; hold_ok = 1; have_req = 0; req_seen = 0;
    r_we = 0; r_addr = 0; r_wdata = 0; r_be = 0; r_rdata = 0;
    op_valid_i = 1; op_i = op; addr_i = addr; wdata_i = wd;
    except_pending_i = 0; pipe_flush_i = 0; pipe_stall_i = (hold > 0);
    for (int c = 0; c < 100 && done_cyc < 0; c++) begin
      req_ready_i = 0; rsp_valid_i = 0; rsp_rdata_i = $urandom;
      if (req_o) begin
        req_ready_i = (req_seen >= rdly);
        req_seen++;
        rsp_valid_i = junk;
      end else if (c == 0) begin
        rsp_valid_i = junk;
      end else if (acc_cyc >= 0 && rspd > 0 && c == acc_cyc + rspd) begin
        rsp_valid_i = 1; rsp_rdata_i = raw;
      end
      @(negedge clk);
      if (bus_err_o) begin berr_cnt++; berr_cyc = c; end
      if (acc_cyc >= 0 && c > acc_cyc && !mem_stall_o) begin
        done_cyc = c; r_rdata = rdata_o;
      end else if (!mem_stall_o) begin
        stall_ok = 0;
      end
      if (req_o) begin
        if (!have_req) begin
          r_we = req_we_o; r_addr = req_addr_o; r_wdata = req_wdata_o; r_be = req_be_o;
          have_req = 1;
        end else if ({req_we_o, req_addr_o, req_wdata_o, req_be_o} !== {r_we, r_addr, r_wdata, r_be}) begin
          fields_ok = 0;
        end
        if (req_ready_i) begin n_acc++; acc_cyc = c; end
      end
      @(posedge clk); #1;
    end
    req_ready_i = 0; rsp_valid_i = 0;
    if (done_cyc >= 0 && hold > 0) begin
      for (int h = 1; h <= hold; h++) begin
        if (h == hold) pipe_stall_i = 0;
        @(negedge clk);
        if (req_o || mem_stall_o || bus_err_o || rdata_o !== r_rdata) hold_ok = 0;
        @(posedge clk); #1;
      end
    end
    op_valid_i = 0; pipe_stall_i = 0;
    if (done_cyc < 0) do_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    reset = 1;
    @(negedge clk);
    n_checks++;
    if ({mem_stall_o, req_o, req_we_o, bus_err_o, adel_o, ades_o} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b required 000000",
                         {mem_stall_o, req_o, req_we_o, bus_err_o, adel_o, ades_o});
    end
    n_checks++;
    if ({rdata_o, req_addr_o, req_wdata_o, req_be_o, badvaddr_o} !== 132'b0) begin
      n_fail++; $display("FAIL reset_data: rdata %h addr %h wdata %h be %h bva %h required all 0",
                         rdata_o, req_addr_o, req_wdata_o, req_be_o, badvaddr_o);
    end
    @(negedge clk) reset = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_load_lb();
    int acc, dn, bc, bn, na; bit sok, fok, hok; logic we; logic [31:0] ra, rw, rd; logic [3:0] be;
    run_op(3'd0, 32'h80000003, 32'h0, 32'h80AA5511, 0, 1, 0, 0,
           acc, dn, bc, bn, na, sok, fok, hok, we, ra, rw, be, rd);
    n_checks++;
    if (dn !== 3) begin n_fail++; $display("FAIL lb_done_cycle: got %0d required 3", dn); end
    n_checks++;
    if (rd !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_rdata: got %h required FFFFFF80", rd); end
    n_checks++;
    if (sok !== 1'b1) begin n_fail++; $display("FAIL lb_stall: stall dropped before DONE"); end
    n_checks++;
    if ({we, ra} !== {1'b0, 32'h80000000}) begin
      n_fail++; $display("FAIL lb_req: we %b addr %h required 0 80000000", we, ra);
    end
  endtask

  task automatic test_store_sh();
    int acc, dn, bc, bn, na; bit sok, fok, hok; logic we; logic [31:0] ra, rw, rd; logic [3:0] be;
    run_op(3'd6, 32'h80000006, 32'h0000BEEF, 32'h0, 0, 1, 0, 0,
           acc, dn, bc, bn, na, sok, fok, hok, we, ra, rw, be, rd);
    n_checks++;
    if ({we, ra, rw, be} !== {1'b1, 32'h80000004, 32'hBEEFBEEF, 4'b1100}) begin
      n_fail++; $display("FAIL sh_req: we %b addr %h wdata %h be %b required 1 80000004 BEEFBEEF 1100",
                         we, ra, rw, be);
    end
    n_checks++;
    if (dn !== 3) begin n_fail++; $display("FAIL sh_done_cycle: got %0d required 3", dn); end
  endtask

  task automatic test_misaligned();
    logic [2:0]  ops [2] = '{3'd4, 3'd7};
    logic [31:0] ads [2] = '{32'h80000002, 32'h80000001};
    for (int k = 0; k < 2; k++) begin
      op_valid_i = 1; op_i = ops[k]; addr_i = ads[k]; wdata_i = 32'h12345678;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        n_checks++;
        if ({adel_o, ades_o} !== {k == 0, k == 1} || badvaddr_o !== ads[k]) begin
          n_fail++; $display("FAIL misalign_flags[%0d]: adel %b ades %b bva %h required %b %b %h",
                             k, adel_o, ades_o, badvaddr_o, k == 0, k == 1, ads[k]);
        end
        n_checks++;
        if ({req_o, mem_stall_o, mem_is_load_o, mem_is_store_o} !== {2'b00, k == 0, k == 1}) begin
          n_fail++; $display("FAIL misalign_noissue[%0d]: req %b stall %b isld %b isst %b",
                             k, req_o, mem_stall_o, mem_is_load_o, mem_is_store_o);
        end
        @(posedge clk); #1;
      end
    end
    op_valid_i = 0;
  endtask

  task automatic test_backpressure();
    int acc, dn, bc, bn, na; bit sok, fok, hok; logic we; logic [31:0] ra, rw, rd; logic [3:0] be;
    run_op(3'd7, 32'h8000001C, 32'hCAFEF00D, 32'h0, 5, 3, 0, 0,
           acc, dn, bc, bn, na, sok, fok, hok, we, ra, rw, be, rd);
    n_checks++;
    if ({sok, fok, na == 1} !== 3'b111) begin
      n_fail++; $display("FAIL bp_protocol: stall_ok %b fields_stable %b accepts %0d required 1 1 1",
                         sok, fok, na);
    end
    n_checks++;
    if (acc !== 6 || dn !== 10) begin
      n_fail++; $display("FAIL bp_timing: accept %0d done %0d required 6 10", acc, dn);
    end
    n_checks++;
    if ({ra, rw, be} !== {32'h8000001C, 32'hCAFEF00D, 4'hF}) begin
      n_fail++; $display("FAIL bp_fields: addr %h wdata %h be %h", ra, rw, be);
    end
  endtask

  task automatic test_timeout();
    int acc, dn, bc, bn, na; bit sok, fok, hok; logic we; logic [31:0] ra, rw, rd; logic [3:0] be;
    // Stray responses in IDLE/REQ must be ignored; the real one never comes.
    run_op(3'd4, 32'h80000040, 32'h0, 32'h0, 1, 0, 1, 1,
           acc, dn, bc, bn, na, sok, fok, hok, we, ra, rw, be, rd);
    n_checks++;
    if (acc !== 2 || dn !== 2 + T + 1) begin
      n_fail++; $display("FAIL to_timing: accept %0d done %0d required 2 %0d", acc, dn, 2 + T + 1);
    end
    n_checks++;
    if (bn !== 1 || bc !== dn || hok !== 1'b1) begin
      n_fail++; $display("FAIL to_buserr: pulses %0d at %0d hold_ok %b required 1 at %0d", bn, bc, hok, dn);
    end
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL to_rdata: got %h required 0", rd); end
  endtask

  task automatic test_done_hold();
    int acc, dn, bc, bn, na; bit sok, fok, hok; logic we; logic [31:0] ra, rw, rd; logic [3:0] be;
    run_op(3'd1, 32'h80000002, 32'h0, 32'h00F3_0000, 0, 2, 3, 0,
           acc, dn, bc, bn, na, sok, fok, hok, we, ra, rw, be, rd);
    n_checks++;
    if ({hok, na == 1} !== 2'b11 || rd !== 32'h000000F3) begin
      n_fail++; $display("FAIL done_hold: hold_ok %b accepts %0d rdata %h required 1 1 000000F3", hok, na, rd);
    end
  endtask

  task automatic test_no_issue();
    // Exception already pending, then a flush: neither may start a bus access.
    for (int k = 0; k < 2; k++) begin
      op_valid_i = 1; op_i = 3'd4; addr_i = 32'h80000100;
      except_pending_i = (k == 0); pipe_flush_i = (k == 1);
      repeat (2) begin
        @(negedge clk);
        n_checks++;
        if ({req_o, mem_stall_o, adel_o} !== 3'b000) begin
          n_fail++; $display("FAIL no_issue[%0d]: req %b stall %b adel %b required 000", k, req_o, mem_stall_o, adel_o);
        end
        @(posedge clk); #1;
      end
    end
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (req_o !== 1'b0) begin n_fail++; $display("FAIL no_issue_after: req %b required 0", req_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    op_valid_i = 1; op_i = 3'd4; addr_i = 32'h80000200; req_ready_i = 1; rsp_valid_i = 0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({req_o, mem_stall_o} !== 2'b01) begin
      n_fail++; $display("FAIL rmid_wait: req %b stall %b required 0 1", req_o, mem_stall_o);
    end
    reset = 1; op_valid_i = 0; req_ready_i = 0;
    #1;
    n_checks++;
    if ({mem_stall_o, req_o, bus_err_o, rdata_o, req_addr_o, req_be_o, req_we_o} !== 71'b0) begin
      n_fail++; $display("FAIL rmid_outputs: stall %b req %b berr %b rdata %h addr %h be %h we %b required all 0",
                         mem_stall_o, req_o, bus_err_o, rdata_o, req_addr_o, req_be_o, req_we_o);
    end
    @(negedge clk) reset = 0;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({req_o, mem_stall_o} !== 2'b00) begin
      n_fail++; $display("FAIL rmid_idle: req %b stall %b required 0 0", req_o, mem_stall_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int acc, dn, bc, bn, na; bit sok, fok, hok; logic we; logic [31:0] ra, rw, rd; logic [3:0] be;
    logic [2:0] op; logic [31:0] addr, wd, raw;
    int rdly, rspd, hold, exp_acc, exp_done; bit tmo, junk;
    for (int it = 0; it < 40; it++) begin
      op = 3'($urandom_range(0, 7));
      addr = $urandom; wd = $urandom; raw = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr - (addr % ((op == 3'd4 || op == 3'd7) ? 4 : 2));
      if (model_misaligned(op, addr)) begin
        op_valid_i = 1; op_i = op; addr_i = addr;
        @(negedge clk);
        n_checks++;
        if ({adel_o, ades_o, req_o, mem_stall_o} !== {is_ld(op), !is_ld(op), 2'b00} || badvaddr_o !== addr) begin
          n_fail++; $display("FAIL rnd_misalign[%0d]: op %0d addr %h adel %b ades %b req %b stall %b bva %h",
                             it, op, addr, adel_o, ades_o, req_o, mem_stall_o, badvaddr_o);
        end
        @(posedge clk); #1;
        op_valid_i = 0;
        continue;
      end
      rdly = $urandom_range(0, 3); rspd = $urandom_range(0, 6);
      hold = $urandom_range(0, 2); junk = ($urandom_range(0, 3) == 0);
      run_op(op, addr, wd, raw, rdly, rspd, hold, junk,
             acc, dn, bc, bn, na, sok, fok, hok, we, ra, rw, be, rd);
      tmo = (rspd == 0) || (rspd > T);
      exp_acc = 1 + rdly;
      exp_done = exp_acc + (tmo ? T : rspd) + 1;
      n_checks++;
      if (dn !== exp_done || na !== 1 || {sok, fok, hok} !== 3'b111) begin
        n_fail++; $display("FAIL rnd_flow[%0d]: op %0d done %0d acc %0d ok %b%b%b required done %0d acc 1 ok 111",
                           it, op, dn, na, sok, fok, hok, exp_done);
      end
      n_checks++;
      if (bn !== (tmo ? 1 : 0) || (tmo && bc !== exp_done)) begin
        n_fail++; $display("FAIL rnd_buserr[%0d]: pulses %0d at %0d required %0d at %0d", it, bn, bc, tmo, exp_done);
      end
      n_checks++;
      if ({we, ra} !== {!is_ld(op), addr & 32'hFFFFFFFC}) begin
        n_fail++; $display("FAIL rnd_addr[%0d]: we %b addr %h required %b %h", it, we, ra, !is_ld(op), addr & 32'hFFFFFFFC);
      end
      n_checks++;
      if (is_ld(op) && rd !== (tmo ? 32'h0 : model_load(op, addr, raw))) begin
        n_fail++; $display("FAIL rnd_rdata[%0d]: op %0d addr %h raw %h got %h required %h",
                           it, op, addr, raw, rd, tmo ? 32'h0 : model_load(op, addr, raw));
      end else if (!is_ld(op) && {rw, be} !== {model_wdata(op, wd), model_be(op, addr)}) begin
        n_fail++; $display("FAIL rnd_store[%0d]: op %0d addr %h wdata %h be %b required %h %b",
                           it, op, addr, rw, be, model_wdata(op, wd), model_be(op, addr));
      end
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    test_reset();
    test_load_lb();
    test_store_sh();
    test_misaligned();
    test_backpressure();
    test_timeout();
    test_done_hold();
    test_no_issue();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
